// File: rtl/mmss_timer_core.sv
// mmss_timer_core
//   Shared min:sec:centisecond timer for the stopwatch and microwave modes.
//   Counts up or down on a TICK_HZ base tick, supports 30 s-step preset
//   adjust while idle or paused, raises hold_timeout after HOLD_TICKS ticks
//   in PAUSED and pulses expired for one cycle when the count finishes.
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   dir                      0 up / 1 down, latched on the accepted start from IDLE
//   start, pause, clear      command pulses (priority clear > start > pause > inc > dec)
//   inc, dec                 preset adjust pulses (IDLE/PAUSED only)
//   min, sec, cs             current time fields
//   disp                     registered min*100+sec (one cycle behind min/sec)
//   state                    00 IDLE, 01 RUN, 10 PAUSED, 11 DONE
//   running                  state == RUN
//   expired                  one-cycle pulse on entry to DONE
//   hold_timeout             level, set after HOLD_TICKS ticks in PAUSED
module mmss_timer_core #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 100,
    parameter int MAX_MIN    = 99,
    parameter int MIN_W      = 7,
    parameter int STEP_SEC   = 30,
    parameter int HOLD_TICKS = 3000,
    parameter int DISP_W     = 14
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dir,
    input  logic              start,
    input  logic              pause,
    input  logic              clear,
    input  logic              inc,
    input  logic              dec,
    output logic [MIN_W-1:0]  min,
    output logic [5:0]        sec,
    output logic [6:0]        cs,
    output logic [DISP_W-1:0] disp,
    output logic [1:0]        state,
    output logic              running,
    output logic              expired,
    output logic              hold_timeout
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int HW  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_RUN    = 2'b01;
    localparam logic [1:0] S_PAUSED = 2'b10;
    localparam logic [1:0] S_DONE   = 2'b11;

    localparam logic [MIN_W-1:0] MIN_MAX = MIN_W'(MAX_MIN);
    localparam logic [6:0]       STEP7   = 7'(STEP_SEC);

    logic [1:0]       state_q, nxt_state;
    logic [MIN_W-1:0] min_q, nxt_min;
    logic [5:0]       sec_q, nxt_sec;
    logic [6:0]       cs_q, nxt_cs;
    logic             dir_q, nxt_dir;
    logic [PW-1:0]    presc_q;
    logic [HW-1:0]    hold_q;
    logic             hto_q, exp_q;
    logic [DISP_W-1:0] disp_q;

    logic c_clear, c_start, c_pause, c_inc, c_dec;
    logic active, tick, is_zero, is_max;
    logic [6:0] sec_sum;

    // One-hot of the highest-priority pulse; lower pulses in the same cycle are dropped
    // even when the winner has no effect in the current state.
    assign c_clear = clear;
    assign c_start = start & ~clear;
    assign c_pause = pause & ~clear & ~start;
    assign c_inc   = inc & ~clear & ~start & ~pause;
    assign c_dec   = dec & ~clear & ~start & ~pause & ~inc;

    assign active  = (state_q == S_RUN) || (state_q == S_PAUSED);
    assign tick    = active && (presc_q == PW'(DIV - 1));
    assign is_zero = (min_q == '0) && (sec_q == '0) && (cs_q == '0);
    assign is_max  = (min_q == MIN_MAX) && (sec_q == 6'd59) && (cs_q == 7'd99);
    assign sec_sum = {1'b0, sec_q} + STEP7;

    always_comb begin
        nxt_state = state_q;
        nxt_min   = min_q;
        nxt_sec   = sec_q;
        nxt_cs    = cs_q;
        nxt_dir   = dir_q;
        if (c_clear) begin
            nxt_state = S_IDLE;
            nxt_min   = '0;
            nxt_sec   = '0;
            nxt_cs    = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (c_pause) begin
                        nxt_state = S_PAUSED;
                    end else if (tick) begin
                        if (!dir_q) begin
                            // Up: a tick already at the ceiling just finishes; otherwise
                            // finish on the tick that lands on the ceiling.
                            if (is_max) begin
                                nxt_state = S_DONE;
                            end else begin
                                if (cs_q == 7'd99) begin
                                    nxt_cs = '0;
                                    if (sec_q == 6'd59) begin
                                        nxt_sec = '0;
                                        nxt_min = min_q + 1'b1;
                                    end else begin
                                        nxt_sec = sec_q + 1'b1;
                                    end
                                end else begin
                                    nxt_cs = cs_q + 1'b1;
                                end
                                if (min_q == MIN_MAX && sec_q == 6'd59 && cs_q == 7'd98)
                                    nxt_state = S_DONE;
                            end
                        end else begin
                            // Down: a tick at zero (reachable via PAUSED preset) cannot underflow.
                            if (is_zero) begin
                                nxt_state = S_DONE;
                            end else begin
                                if (cs_q == '0) begin
                                    nxt_cs = 7'd99;
                                    if (sec_q == '0) begin
                                        nxt_sec = 6'd59;
                                        nxt_min = min_q - 1'b1;
                                    end else begin
                                        nxt_sec = sec_q - 1'b1;
                                    end
                                end else begin
                                    nxt_cs = cs_q - 1'b1;
                                end
                                if (min_q == '0 && sec_q == '0 && cs_q == 7'd1)
                                    nxt_state = S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (c_start) begin
                        nxt_state = S_IDLE;
                        nxt_min   = '0;
                        nxt_sec   = '0;
                        nxt_cs    = '0;
                    end
                end
                default: begin // IDLE, PAUSED
                    if (c_start) begin
                        if (state_q == S_PAUSED) begin
                            nxt_state = S_RUN;
                        end else if (!(dir && is_zero)) begin
                            nxt_state = S_RUN;
                            nxt_dir   = dir;
                        end
                    end else if (c_inc) begin
                        nxt_cs = '0;
                        if (sec_sum >= 7'd60) begin
                            if (min_q == MIN_MAX) begin
                                nxt_sec = 6'd59;
                            end else begin
                                nxt_sec = 6'(sec_sum - 7'd60);
                                nxt_min = min_q + 1'b1;
                            end
                        end else begin
                            nxt_sec = sec_sum[5:0];
                        end
                    end else if (c_dec) begin
                        nxt_cs = '0;
                        if (min_q == '0 && {1'b0, sec_q} <= STEP7) begin
                            nxt_sec = '0;
                        end else if ({1'b0, sec_q} < STEP7) begin
                            nxt_sec = 6'({1'b0, sec_q} + 7'd60 - STEP7);
                            nxt_min = min_q - 1'b1;
                        end else begin
                            nxt_sec = sec_q - STEP7[5:0];
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            min_q   <= '0;
            sec_q   <= '0;
            cs_q    <= '0;
            dir_q   <= 1'b0;
            presc_q <= '0;
            hold_q  <= '0;
            hto_q   <= 1'b0;
            exp_q   <= 1'b0;
            disp_q  <= '0;
        end else begin
            state_q <= nxt_state;
            min_q   <= nxt_min;
            sec_q   <= nxt_sec;
            cs_q    <= nxt_cs;
            dir_q   <= nxt_dir;
            exp_q   <= (nxt_state == S_DONE) && (state_q != S_DONE);
            disp_q  <= DISP_W'(min_q) * DISP_W'(100) + DISP_W'(sec_q);

            // Prescaler restarts on every state change so each state sees full tick periods.
            if (nxt_state != state_q || !active || tick)
                presc_q <= '0;
            else
                presc_q <= presc_q + 1'b1;

            // Counter freezes at HOLD_TICKS-1 once the timeout is flagged.
            if (nxt_state != S_PAUSED) begin
                hold_q <= '0;
                hto_q  <= 1'b0;
            end else if (state_q == S_PAUSED && tick) begin
                if (hold_q == HW'(HOLD_TICKS - 1))
                    hto_q <= 1'b1;
                else
                    hold_q <= hold_q + 1'b1;
            end
        end
    end

    assign min          = min_q;
    assign sec          = sec_q;
    assign cs           = cs_q;
    assign disp         = disp_q;
    assign state        = state_q;
    assign running      = (state_q == S_RUN);
    assign expired      = exp_q;
    assign hold_timeout = hto_q;
endmodule
